// File: rtl/mrnaiso_valve_sequencer_if.sv
// Command/status bundle between the isolation-bank sequencer and its host.
// The host owns start/abort/hold; the sequencer owns the valve lines and status.
interface mrnaiso_valve_sequencer_if;
    logic        start;
    logic        abort;
    logic        hold;
    logic [12:0] valve_ctrl;
    logic [2:0]  phase;
    logic        busy;
    logic        done;
    logic        aborted;

    modport master (
        output start, abort, hold,
        input  valve_ctrl, phase, busy, done, aborted
    );

    modport slave (
        input  start, abort, hold,
        output valve_ctrl, phase, busy, done, aborted
    );
endinterface

// File: rtl/mrnaiso_valve_sequencer.sv
// Steps the mRNA isolation protocol and drives the 13 ctrl-pad solenoids.
// A valve bit of 1 means pressurised/closed; all outputs come straight from flops.
module mrnaiso_valve_sequencer #(
    parameter int TICK_DIV      = 1000,
    parameter int LOAD_TICKS    = 50,
    parameter int LYSIS_TICKS   = 20,
    parameter int MIX_STEPS     = 60,
    parameter int WASH_TICKS    = 40,
    parameter int COLLECT_TICKS = 30
) (
    input  logic                         clk,
    input  logic                         rst,
    mrnaiso_valve_sequencer_if.slave     bus
);

    localparam int PW    = $clog2(TICK_DIV + 1);
    localparam int MAXA  = (LOAD_TICKS > LYSIS_TICKS) ? LOAD_TICKS : LYSIS_TICKS;
    localparam int MAXB  = (MIX_STEPS > WASH_TICKS) ? MIX_STEPS : WASH_TICKS;
    localparam int MAXC  = (MAXA > MAXB) ? MAXA : MAXB;
    localparam int MAX_T = (MAXC > COLLECT_TICKS) ? MAXC : COLLECT_TICKS;
    localparam int TW    = $clog2(MAX_T) + 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BEADS   = 3'd1,
        S_CELLS   = 3'd2,
        S_LYSIS   = 3'd3,
        S_MIX     = 3'd4,
        S_WASH    = 3'd5,
        S_COLLECT = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    pump_q, pump_d;
    logic [12:0]   valve_q, valve_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          aborted_q, aborted_d;
    logic [TW-1:0] termTicks;
    logic [2:0]    pumps;

    always_comb begin
        termTicks = '0;
        case (state_q)
            S_BEADS, S_CELLS: termTicks = TW'(LOAD_TICKS - 1);
            S_LYSIS:          termTicks = TW'(LYSIS_TICKS - 1);
            S_MIX:            termTicks = TW'(MIX_STEPS - 1);
            S_WASH:           termTicks = TW'(WASH_TICKS - 1);
            S_COLLECT:        termTicks = TW'(COLLECT_TICKS - 1);
            default:          termTicks = '0;
        endcase
    end

    // DONE is untimed and always exits after one cycle so done stays a true pulse.
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        tick_d    = tick_q;
        pump_d    = pump_q;
        aborted_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!bus.abort && bus.start) state_d = S_BEADS;
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (bus.abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (!bus.hold) begin
                    if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        if (tick_q == termTicks) begin
                            state_d = state_t'(state_q + 3'd1);
                        end else begin
                            tick_d = tick_q + 1'b1;
                            if (state_q == S_MIX)
                                pump_d = (pump_q == 3'd5) ? 3'd0 : pump_q + 3'd1;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
            end
        endcase
        if (state_d != state_q) begin
            pre_d  = '0;
            tick_d = '0;
            pump_d = '0;
        end
    end

    // Peristaltic pattern as {pump1,pump2,pump3}; a 0 is the open (vented) valve.
    always_comb begin
        pumps = 3'b111;
        case (pump_d)
            3'd0:    pumps = 3'b011;
            3'd1:    pumps = 3'b001;
            3'd2:    pumps = 3'b101;
            3'd3:    pumps = 3'b100;
            3'd4:    pumps = 3'b110;
            3'd5:    pumps = 3'b010;
            default: pumps = 3'b111;
        endcase
    end

    always_comb begin
        valve_d = 13'h1FFF;
        case (state_d)
            S_BEADS:   begin valve_d[10] = 1'b0; valve_d[9]  = 1'b0; end
            S_CELLS:   begin valve_d[11] = 1'b0; valve_d[12] = 1'b0; end
            S_LYSIS:   begin valve_d[1]  = 1'b0; valve_d[2]  = 1'b0; end
            S_MIX:     begin
                valve_d[4] = pumps[2];
                valve_d[5] = pumps[1];
                valve_d[6] = pumps[0];
            end
            S_WASH:    begin valve_d[3]  = 1'b0; valve_d[9]  = 1'b0; end
            S_COLLECT: begin valve_d[3]  = 1'b0; valve_d[0]  = 1'b0; end
            default:   valve_d = 13'h1FFF;
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pre_q     <= '0;
            tick_q    <= '0;
            pump_q    <= '0;
            valve_q   <= 13'h1FFF;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            pump_q    <= pump_d;
            valve_q   <= valve_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.valve_ctrl = valve_q;
    assign bus.phase      = state_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;

endmodule

// File: tb/tb_mrnaiso_valve_sequencer.sv
// Scoreboard bench for the valve sequencer with a short protocol configuration.
// Stimulus queues one expected output record per cycle; a monitor pops and compares.
module tb_mrnaiso_valve_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mrnaiso_valve_sequencer_if busIf();

    mrnaiso_valve_sequencer #(
        .TICK_DIV      (2),
        .LOAD_TICKS    (3),
        .LYSIS_TICKS   (2),
        .MIX_STEPS     (7),
        .WASH_TICKS    (2),
        .COLLECT_TICKS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    typedef struct {
        logic [12:0] valve;
        logic [2:0]  phase;
        logic        busy;
        logic        done;
        logic        aborted;
        int          scen;
        int          idx;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   scen   = 0;
    int   recIdx = 0;

    task automatic applyStimulus(input logic s, input logic a, input logic h);
        busIf.start = s;
        busIf.abort = a;
        busIf.hold  = h;
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (busIf.valve_ctrl !== e.valve || busIf.phase !== e.phase ||
            busIf.busy !== e.busy || busIf.done !== e.done || busIf.aborted !== e.aborted) begin
            errors++;
            $display("[TB] FAIL scen%0d rec%0d: got valve=%h phase=%0d busy=%b done=%b aborted=%b, want valve=%h phase=%0d busy=%b done=%b aborted=%b",
                     e.scen, e.idx, busIf.valve_ctrl, busIf.phase, busIf.busy, busIf.done,
                     busIf.aborted, e.valve, e.phase, e.busy, e.done, e.aborted);
        end
    endtask

    task automatic pushSeg(input logic [12:0] v, input logic [2:0] ph, input logic b,
                           input logic d, input logic a, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.valve = v; e.phase = ph; e.busy = b; e.done = d; e.aborted = a;
            e.scen = scen; e.idx = recIdx;
            recIdx++;
            sbq.push_back(e);
        end
    endtask

    task automatic pushIdle(input int n);
        pushSeg(13'h1FFF, 3'd0, 1'b0, 1'b0, 1'b0, n);
    endtask

    // MIX valve words with pump1/2/3 on bits 4/5/6, two cycles per step.
    task automatic pushMix();
        pushSeg(13'h1FEF, 3'd4, 1'b1, 1'b0, 1'b0, 2);
        pushSeg(13'h1FCF, 3'd4, 1'b1, 1'b0, 1'b0, 2);
        pushSeg(13'h1FDF, 3'd4, 1'b1, 1'b0, 1'b0, 2);
        pushSeg(13'h1F9F, 3'd4, 1'b1, 1'b0, 1'b0, 2);
        pushSeg(13'h1FBF, 3'd4, 1'b1, 1'b0, 1'b0, 2);
        pushSeg(13'h1FAF, 3'd4, 1'b1, 1'b0, 1'b0, 2);
        pushSeg(13'h1FEF, 3'd4, 1'b1, 1'b0, 1'b0, 2);
    endtask

    task automatic pushRun(input int cellsLen);
        pushSeg(13'h19FF, 3'd1, 1'b1, 1'b0, 1'b0, 6);
        pushSeg(13'h07FF, 3'd2, 1'b1, 1'b0, 1'b0, cellsLen);
        pushSeg(13'h1FF9, 3'd3, 1'b1, 1'b0, 1'b0, 4);
        pushMix();
        pushSeg(13'h1DF7, 3'd5, 1'b1, 1'b0, 1'b0, 4);
        pushSeg(13'h1FF6, 3'd6, 1'b1, 1'b0, 1'b0, 4);
        pushSeg(13'h1FFF, 3'd7, 1'b0, 1'b1, 1'b0, 1);
        pushIdle(1);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL scen%0d drain: got %0d records pending, want 0", scen, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic nextScen();
        scen++;
        recIdx = 0;
    endtask

    // Reset is watched as well so its effect is checked before any clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset state");
        @(negedge clk);
        pushIdle(2);
        waitDrain();

        $display("[TB] full run, abort during DONE ignored");
        nextScen();
        @(negedge clk);
        pushRun(6);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (38) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitDrain();

        $display("[TB] start with abort in IDLE");
        nextScen();
        @(negedge clk);
        pushIdle(3);
        applyStimulus(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitDrain();

        $display("[TB] abort during LYSIS");
        nextScen();
        @(negedge clk);
        pushSeg(13'h19FF, 3'd1, 1'b1, 1'b0, 1'b0, 6);
        pushSeg(13'h07FF, 3'd2, 1'b1, 1'b0, 1'b0, 6);
        pushSeg(13'h1FF9, 3'd3, 1'b1, 1'b0, 1'b0, 2);
        pushSeg(13'h1FFF, 3'd0, 1'b0, 1'b0, 1'b1, 1);
        pushIdle(2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (13) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitDrain();

        $display("[TB] restart after abort, extra start during BEADS");
        nextScen();
        @(negedge clk);
        pushRun(6);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitDrain();

        $display("[TB] hold for 5 cycles during CELLS");
        nextScen();
        @(negedge clk);
        pushRun(11);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitDrain();

        $display("[TB] async reset during MIX");
        nextScen();
        @(negedge clk);
        pushSeg(13'h19FF, 3'd1, 1'b1, 1'b0, 1'b0, 6);
        pushSeg(13'h07FF, 3'd2, 1'b1, 1'b0, 1'b0, 6);
        pushSeg(13'h1FF9, 3'd3, 1'b1, 1'b0, 1'b0, 4);
        pushSeg(13'h1FEF, 3'd4, 1'b1, 1'b0, 1'b0, 2);
        pushSeg(13'h1FCF, 3'd4, 1'b1, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (18) @(negedge clk);
        pushIdle(5);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        waitDrain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
